// File: rtl/barrel_shift_pipe_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package barrel_shift_pipe_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROL = 2'd3
  } shift_op_t;

  // First shift level handled by stage s when l levels are spread over stages.
  function automatic int level_lo(input int s, input int l, input int stages);
    return (s * l) / stages;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One conditional shift level (by SHAMT) in any of the four modes.
// Sticky in/out ports exist only when BARREL_SHIFT_PIPE_STICKY_EN is defined.
module barrel_shift_level
  import barrel_shift_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHAMT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_t        op_i,
  input  logic             en_i,
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
  input  logic             sticky_i,
  output logic             sticky_o,
`endif
  output logic [WIDTH-1:0] data_o
);

  // ASR keeps the MSB in place at every level, so the sign captured at input survives.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        LSL:     data_o = data_i << SHAMT;
        LSR:     data_o = data_i >> SHAMT;
        ASR:     data_o = $signed(data_i) >>> SHAMT;
        ROL:     data_o = {data_i[WIDTH-SHAMT-1:0], data_i[WIDTH-1:WIDTH-SHAMT]};
        default: data_o = data_i;
      endcase
    end
  end

`ifdef BARREL_SHIFT_PIPE_STICKY_EN
  always_comb begin
    sticky_o = sticky_i;
    if (en_i) begin
      case (op_i)
        LSL:     sticky_o = sticky_i | (|data_i[WIDTH-1 -: SHAMT]);
        LSR,
        ASR:     sticky_o = sticky_i | (|data_i[SHAMT-1:0]);
        default: sticky_o = sticky_i;
      endcase
    end
  end
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined four-mode barrel shifter with valid/ready at both ends.
// Optional out_sticky output enabled by BARREL_SHIFT_PIPE_STICKY_EN.
module barrel_shift_pipe
  import barrel_shift_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_bits,
  input  logic [$clog2(WIDTH)-1:0] in_shift,
  input  logic [OP_W-1:0]          in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
  output logic                     out_sticky,
`endif
  output logic [WIDTH-1:0]         out_bits
);

  localparam int L = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shift_pipe: WIDTH must be a power of two in 2..64");
  end
  if (STAGES < 1 || STAGES > L) begin : g_bad_stages
    $error("barrel_shift_pipe: STAGES must be in 1..clog2(WIDTH)");
  end

  logic [STAGES-1:0] vld;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = level_lo(s, L, STAGES);
    localparam int HI = level_lo(s + 1, L, STAGES);
    localparam int N  = HI - LO;

    logic             v_in;
    logic             rdy;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    shift_op_t        op_in;
    logic [L-LO-1:0]  sh_in;
    logic [WIDTH-1:0] data_d [N+1];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    logic             sticky_q;
    logic             sticky_d [N+1];
`endif

    // Expanded form of ready_s = !valid_s || ready_(s+1): no comb chain between stages.
    assign rdy    = out_ready || !(&vld[STAGES-1:s]);
    assign vld[s] = valid_q;

    if (s == 0) begin : g_src
      assign v_in      = in_valid;
      assign data_d[0] = in_bits;
      assign op_in     = shift_op_t'(in_op);
      assign sh_in     = in_shift;
      assign in_ready  = rdy && !rst;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
      assign sticky_d[0] = 1'b0;
`endif
    end else begin : g_src
      assign v_in      = g_st[s-1].valid_q;
      assign data_d[0] = g_st[s-1].data_q;
      assign op_in     = g_st[s-1].g_fwd.op_q;
      assign sh_in     = g_st[s-1].g_fwd.sh_q;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
      assign sticky_d[0] = g_st[s-1].sticky_q;
`endif
    end

    for (genvar k = 0; k < N; k++) begin : g_lvl
      barrel_shift_level #(
        .WIDTH (WIDTH),
        .SHAMT (2 ** (LO + k))
      ) u_lvl (
        .data_i   (data_d[k]),
        .op_i     (op_in),
        .en_i     (sh_in[k]),
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
        .sticky_i (sticky_d[k]),
        .sticky_o (sticky_d[k+1]),
`endif
        .data_o   (data_d[k+1])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (rdy) begin
        valid_q <= v_in;
        if (v_in) data_q <= data_d[N];
      end
    end

`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    always_ff @(posedge clk) begin
      if (rst) sticky_q <= 1'b0;
      else if (rdy && v_in) sticky_q <= sticky_d[N];
    end
`endif

    // Only stages with levels still pending carry op and the unconsumed shift bits.
    if (HI < L) begin : g_fwd
      shift_op_t      op_q;
      logic [L-HI-1:0] sh_q;
      always_ff @(posedge clk) begin
        if (!rst && rdy && v_in) begin
          op_q <= op_in;
          sh_q <= sh_in[L-LO-1:N];
        end
      end
    end

    if (s == STAGES - 1) begin : g_last
      assign out_valid = valid_q;
      assign out_bits  = data_q;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
      assign out_sticky = sticky_q;
`endif
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe at STAGES=1/2/3 (WIDTH=8); checks
// out_sticky too when BARREL_SHIFT_PIPE_STICKY_EN is defined.
module tb_barrel_shift_pipe;
  import barrel_shift_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_bits;
  logic [2:0] in_shift;
  logic [1:0] in_op;
  logic       ir [3];
  logic       ov [3];
  logic [7:0] ob [3];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
  logic       os [3];
  logic       st_r [3];
`endif

  int         n_vec = 0;
  int         n_err = 0;
  int         lat_r [3];
  logic [7:0] bits_r [3];

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_bits(in_bits),
    .in_shift(in_shift), .in_op(in_op), .out_valid(ov[0]), .out_ready(out_ready),
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    .out_sticky(os[0]),
`endif
    .out_bits(ob[0]));

  barrel_shift_pipe #(.WIDTH(8), .STAGES(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_bits(in_bits),
    .in_shift(in_shift), .in_op(in_op), .out_valid(ov[1]), .out_ready(out_ready),
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    .out_sticky(os[1]),
`endif
    .out_bits(ob[1]));

  barrel_shift_pipe #(.WIDTH(8), .STAGES(3)) dut_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_bits(in_bits),
    .in_shift(in_shift), .in_op(in_op), .out_valid(ov[2]), .out_ready(out_ready),
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    .out_sticky(os[2]),
`endif
    .out_bits(ob[2]));

  typedef struct {
    logic [1:0] op;
    logic [2:0] sh;
    logic [7:0] d;
    logic [7:0] exp;
    logic       st;
  } vec_t;

  vec_t tbl [16];

  // Bitwise reference, written independently of the level decomposition.
  function automatic logic [7:0] ref_shift(input logic [1:0] op, input int sh, input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (op)
        2'd0: r[i] = (i >= sh) ? d[(i - sh) & 7] : 1'b0;
        2'd1: r[i] = (i + sh < 8) ? d[(i + sh) & 7] : 1'b0;
        2'd2: r[i] = (i + sh < 8) ? d[(i + sh) & 7] : d[7];
        default: r[i] = d[(i - sh + 8) % 8];
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_sticky(input logic [1:0] op, input int sh, input logic [7:0] d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (op == 2'd0 && i >= 8 - sh) r = r | d[i];
      if ((op == 2'd1 || op == 2'd2) && i < sh) r = r | d[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Single isolated word on all three DUTs; records per-DUT latency and result.
  task automatic run_single(input logic [1:0] op, input logic [2:0] sh, input logic [7:0] d);
    int w;
    @(negedge clk);
    in_op = op; in_shift = sh; in_bits = d; in_valid = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      lat_r[j] = -1;
      bits_r[j] = '0;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
      st_r[j] = 1'b0;
`endif
    end
    #1;
    w = 0;
    while (!(ir[0] && ir[1] && ir[2]) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 20) chk("accept_timeout", 32'(w), 32'(0));
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
        if (ov[j] && lat_r[j] < 0) begin
          lat_r[j] = c;
          bits_r[j] = ob[j];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
          st_r[j] = os[j];
`endif
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got [$];
    int         got_cyc [$];
    logic [7:0] hold;
    logic       have_hold;
    int         idx;
    int         ghosts;
    logic [7:0] d;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_bits = '0; in_shift = '0; in_op = '0;

    tbl[0]  = '{2'd0, 3'd3, 8'h81, 8'h08, 1'b1};
    tbl[1]  = '{2'd1, 3'd3, 8'h81, 8'h10, 1'b1};
    tbl[2]  = '{2'd2, 3'd2, 8'h90, 8'hE4, 1'b0};
    tbl[3]  = '{2'd3, 3'd1, 8'h81, 8'h03, 1'b0};
    tbl[4]  = '{2'd0, 3'd0, 8'hA5, 8'hA5, 1'b0};
    tbl[5]  = '{2'd1, 3'd0, 8'hA5, 8'hA5, 1'b0};
    tbl[6]  = '{2'd2, 3'd0, 8'hA5, 8'hA5, 1'b0};
    tbl[7]  = '{2'd3, 3'd0, 8'hA5, 8'hA5, 1'b0};
    tbl[8]  = '{2'd0, 3'd7, 8'hFF, 8'h80, 1'b1};
    tbl[9]  = '{2'd1, 3'd7, 8'hFF, 8'h01, 1'b1};
    tbl[10] = '{2'd2, 3'd7, 8'h80, 8'hFF, 1'b0};
    tbl[11] = '{2'd3, 3'd7, 8'h01, 8'h80, 1'b0};
    tbl[12] = '{2'd2, 3'd7, 8'h7F, 8'h00, 1'b1};
    tbl[13] = '{2'd1, 3'd2, 8'h07, 8'h01, 1'b1};
    tbl[14] = '{2'd1, 3'd2, 8'h04, 8'h01, 1'b0};
    tbl[15] = '{2'd3, 3'd4, 8'h3C, 8'hC3, 1'b0};

    // Reset state while rst is still high.
    repeat (2) @(negedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("reset_out_valid_s%0d", j + 1), 32'(ov[j]), 32'(0));
      chk($sformatf("reset_out_bits_s%0d", j + 1), 32'(ob[j]), 32'(0));
      chk($sformatf("reset_in_ready_s%0d", j + 1), 32'(ir[j]), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(ir[1]), 32'(1));

    // Hand-computed table on the STAGES=2 instance.
    for (int i = 0; i < 16; i++) begin
      run_single(tbl[i].op, tbl[i].sh, tbl[i].d);
      chk($sformatf("tbl%0d_latency", i), 32'(lat_r[1]), 32'(2));
      chk($sformatf("tbl%0d_bits", i), 32'(bits_r[1]), 32'(tbl[i].exp));
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
      chk($sformatf("tbl%0d_sticky", i), 32'(st_r[1]), 32'(tbl[i].st));
`endif
    end

    // Every op and amount on all three stage counts against the reference.
    for (int op = 0; op < 4; op++) begin
      for (int sh = 0; sh < 8; sh++) begin
        for (int di = 0; di < 2; di++) begin
          d = (di == 0) ? 8'h3D : 8'hB4;
          run_single(2'(op), 3'(sh), d);
          for (int j = 0; j < 3; j++) begin
            chk($sformatf("sweep_s%0d_op%0d_sh%0d_d%0h_lat", j + 1, op, sh, d), 32'(lat_r[j]), 32'(j + 1));
            chk($sformatf("sweep_s%0d_op%0d_sh%0d_d%0h_bits", j + 1, op, sh, d),
                32'(bits_r[j]), 32'(ref_shift(2'(op), sh, d)));
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            chk($sformatf("sweep_s%0d_op%0d_sh%0d_d%0h_sticky", j + 1, op, sh, d),
                32'(st_r[j]), 32'(ref_sticky(2'(op), sh, d)));
`endif
          end
        end
      end
    end

    // Back-to-back stream: one result per cycle, in order, no gaps.
    got.delete(); got_cyc.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 8) begin
        in_valid = 1'b1; in_op = 2'(c % 4); in_shift = 3'(c); in_bits = 8'h5A ^ 8'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (ov[1]) begin
        got.push_back(ob[1]);
        got_cyc.push_back(c);
      end
    end
    chk("b2b_count", 32'(got.size()), 32'(8));
    for (int j = 0; j < got.size() && j < 8; j++) begin
      chk($sformatf("b2b_word%0d", j), 32'(got[j]), 32'(ref_shift(2'(j % 4), j, 8'h5A ^ 8'(j))));
      chk($sformatf("b2b_cycle%0d", j), 32'(got_cyc[j]), 32'(j + 2));
    end

    // Backpressure: stall 5 cycles, then release and drain.
    got.delete();
    idx = 0; have_hold = 1'b0; hold = '0;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (idx < 6);
      in_op     = 2'((idx + 1) % 4);
      in_shift  = 3'(7 - idx);
      in_bits   = 8'(17 * (idx + 1));
      #1;
      if (c < 5) chk($sformatf("bp_in_ready_c%0d", c), 32'(ir[1]), 32'(idx < 2));
      if (ov[1] && !out_ready) begin
        if (have_hold) chk($sformatf("bp_hold_c%0d", c), 32'(ob[1]), 32'(hold));
        hold = ob[1];
        have_hold = 1'b1;
      end
      if (ov[1] && out_ready) got.push_back(ob[1]);
      if (in_valid && ir[1]) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_count", 32'(got.size()), 32'(6));
    for (int j = 0; j < got.size() && j < 6; j++)
      chk($sformatf("bp_word%0d", j), 32'(got[j]),
          32'(ref_shift(2'((j + 1) % 4), 7 - j, 8'(17 * (j + 1)))));
    repeat (5) @(negedge clk);

    // Reset with two words in flight; a third word offered during reset is refused.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'd0; in_shift = 3'd1; in_bits = 8'h0F;
    @(negedge clk);
    in_op = 2'd3; in_shift = 3'd2; in_bits = 8'hC1;
    @(negedge clk);
    in_op = 2'd1; in_shift = 3'd3; in_bits = 8'hF0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ir[1]), 32'(0));
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov[1]), 32'(0));
    chk("rst_out_bits", 32'(ob[1]), 32'(0));
    ghosts = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (ov[1]) ghosts++;
    end
    chk("rst_ghosts", 32'(ghosts), 32'(0));
    run_single(2'd2, 3'd3, 8'hA0);
    chk("rst_fresh_latency", 32'(lat_r[1]), 32'(2));
    chk("rst_fresh_bits", 32'(bits_r[1]), 32'(8'hF4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
